// File: rtl/mem_adaptor_pkg.sv
// Shared types and constants for the cache-line to memory-burst adaptor.
package mem_adaptor_pkg;

  localparam int BEAT_W      = 64;
  localparam int BURST_LEN   = 4;
  localparam int LINE_W      = BEAT_W * BURST_LEN;
  localparam int OFFSET_BITS = 5;
  localparam int ADDR_W      = 32;

  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } adaptor_state_t;

  // Clears the byte-offset bits so the burst always starts on a line boundary.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'((1 << OFFSET_BITS) - 1);
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Modulo-BURST_LEN beat index with increment, clear and last-beat flag.
module beat_counter #(
  parameter int BURST_LEN = 4,
  localparam int CNT_BITS = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count,
  output logic                last
);

  localparam logic [CNT_BITS-1:0] LAST_VAL = CNT_BITS'(BURST_LEN - 1);

  assign last = (count == LAST_VAL);

  // Advance on each handshake, wrapping after the final beat of the burst.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/cacheline_mem_adaptor.sv
// Splits one cache-line fill/writeback into a burst of memory beats.
module cacheline_mem_adaptor #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 line_addr,
  input  logic                        line_read,
  input  logic                        line_write,
  input  logic [BEAT_W*BURST_LEN-1:0] line_wdata,
  output logic [BEAT_W*BURST_LEN-1:0] line_rdata,
  output logic                        line_resp,
  output logic [31:0]                 mem_address,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [BEAT_W-1:0]           mem_wdata,
  input  logic [BEAT_W-1:0]           mem_rdata,
  input  logic                        mem_resp,
  output logic [CNT_W-1:0]            num_xfers,
  output logic [CNT_W-1:0]            num_busy
);

  import mem_adaptor_pkg::*;

  localparam int LINE_W   = BEAT_W * BURST_LEN;
  localparam int CNT_BITS = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  adaptor_state_t      state;
  adaptor_state_t      next_state;
  logic [CNT_BITS-1:0] beat;
  logic                last_beat;
  logic                beat_inc;
  logic                beat_clr;
  logic [LINE_W-1:0]   wdata_buf;

  assign mem_read  = (state == RD);
  assign mem_write = (state == WR);
  assign line_resp = (state == DONE);
  assign mem_wdata = (state == WR) ? wdata_buf[int'(beat)*BEAT_W +: BEAT_W] : '0;
  assign beat_inc  = mem_resp && ((state == RD) || (state == WR));
  assign beat_clr  = (state == DONE);

  beat_counter #(.BURST_LEN(BURST_LEN)) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (beat_clr),
    .inc   (beat_inc),
    .count (beat),
    .last  (last_beat)
  );

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Writes take priority over reads; a burst ends on the last beat's handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (line_write) begin
          next_state = WR;
        end else if (line_read) begin
          next_state = RD;
        end
      end
      RD, WR: begin
        if (mem_resp && last_beat) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture the request only at acceptance so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_address <= '0;
      wdata_buf   <= '0;
    end else if (state == IDLE) begin
      if (line_write) begin
        mem_address <= align_addr(line_addr);
        wdata_buf   <= line_wdata;
      end else if (line_read) begin
        mem_address <= align_addr(line_addr);
      end
    end
  end

  // Assemble the fill line one beat at a time; old contents persist otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_rdata <= '0;
    end else if ((state == RD) && mem_resp) begin
      line_rdata[int'(beat)*BEAT_W +: BEAT_W] <= mem_rdata;
    end
  end

  // Performance counters: busy cycles and completed transactions, free-running.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_busy  <= '0;
      num_xfers <= '0;
    end else begin
      if (state != IDLE) begin
        num_busy <= num_busy + 1'b1;
      end
      if (state == DONE) begin
        num_xfers <= num_xfers + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cacheline_mem_adaptor.sv
// Directed self-checking bench for the cache-line burst adaptor.
module tb_cacheline_mem_adaptor;

  logic         clk;
  logic         rst;
  logic [31:0]  line_addr;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  num_xfers;
  logic [31:0]  num_busy;

  int compared;
  int mismatched;

  cacheline_mem_adaptor #(.BEAT_W(64), .BURST_LEN(4), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .line_addr   (line_addr),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_wdata  (line_wdata),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .num_xfers   (num_xfers),
    .num_busy    (num_busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [255:0] wd);
    line_read  = rd;
    line_write = wr;
    line_addr  = addr;
    line_wdata = wd;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Returns the four beats back to back; ends in the cycle after the last capture.
  task automatic serveRead(input logic [255:0] line);
    for (int b = 0; b < 4; b++) begin
      checkOutput("rd_no_early_resp", 256'(line_resp), 256'(0));
      mem_resp  = 1'b1;
      mem_rdata = line[b*64 +: 64];
      tick();
    end
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  logic [255:0] fill_a, wline, wline2, fill_c, fill_d, fill_e, fill_f;

  initial begin
    compared   = 0;
    mismatched = 0;
    fill_a = {64'h3, 64'h2, 64'h1, 64'h0};
    wline  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    wline2 = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
    fill_c = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    fill_d = {64'hD3D3, 64'hD2D2, 64'hD1D1, 64'hD0D0};
    fill_e = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
    fill_f = {64'hF3, 64'hF2, 64'hF1, 64'hF0};

    rst       = 1'b1;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    tick();
    tick();

    // Reset values
    checkOutput("rst_mem_read",  256'(mem_read),    256'(0));
    checkOutput("rst_mem_write", 256'(mem_write),   256'(0));
    checkOutput("rst_line_resp", 256'(line_resp),   256'(0));
    checkOutput("rst_rdata",     line_rdata,        256'(0));
    checkOutput("rst_addr",      256'(mem_address), 256'(0));
    checkOutput("rst_wdata",     256'(mem_wdata),   256'(0));
    checkOutput("rst_xfers",     256'(num_xfers),   256'(0));
    checkOutput("rst_busy",      256'(num_busy),    256'(0));
    rst = 1'b0;

    // Zero-wait fill: line_resp lands five edges after acceptance
    applyStimulus(1'b1, 1'b0, 32'h6000_0024, '0);
    tick();
    checkOutput("fill_mem_read", 256'(mem_read),    256'(1));
    checkOutput("fill_addr",     256'(mem_address), 256'(32'h6000_0020));
    tick();
    serveRead(fill_a);
    checkOutput("fill_resp",     256'(line_resp), 256'(1));
    checkOutput("fill_rdata",    line_rdata,      fill_a);
    checkOutput("fill_read_low", 256'(mem_read),  256'(0));
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    tick();
    checkOutput("fill_resp_once", 256'(line_resp), 256'(0));
    checkOutput("fill_xfers",     256'(num_xfers), 256'(1));
    checkOutput("fill_busy",      256'(num_busy),  256'(6));
    checkOutput("fill_rdata_hold", line_rdata,     fill_a);

    // Writeback with two wait cycles ahead of every beat
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h1234_5678, wline);
    tick();
    checkOutput("wb_mem_write", 256'(mem_write),   256'(1));
    checkOutput("wb_addr",      256'(mem_address), 256'(32'h1234_5660));
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, '1);
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 2; w++) begin
        mem_resp = 1'b0;
        checkOutput("wb_write_held", 256'(mem_write), 256'(1));
        tick();
      end
      checkOutput("wb_beat_data", 256'(mem_wdata), 256'(wline[b*64 +: 64]));
      mem_resp = 1'b1;
      tick();
    end
    mem_resp = 1'b0;
    checkOutput("wb_resp",      256'(line_resp),   256'(1));
    checkOutput("wb_write_low", 256'(mem_write),   256'(0));
    checkOutput("wb_busy_done", 256'(num_busy),    256'(12));
    checkOutput("wb_addr_held", 256'(mem_address), 256'(32'h1234_5660));
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    tick();
    checkOutput("wb_resp_once", 256'(line_resp), 256'(0));
    checkOutput("wb_xfers",     256'(num_xfers), 256'(1));
    checkOutput("wb_busy",      256'(num_busy),  256'(13));

    // Both requests together: write first, read re-accepted afterwards
    doReset();
    applyStimulus(1'b1, 1'b1, 32'h0000_1000, wline2);
    tick();
    checkOutput("both_write", 256'(mem_write), 256'(1));
    for (int b = 0; b < 4; b++) begin
      checkOutput("both_no_read", 256'(mem_read),  256'(0));
      checkOutput("both_wdata",   256'(mem_wdata), 256'(wline2[b*64 +: 64]));
      mem_resp = 1'b1;
      tick();
    end
    mem_resp = 1'b0;
    checkOutput("both_wr_resp", 256'(line_resp), 256'(1));
    checkOutput("both_no_read_done", 256'(mem_read), 256'(0));
    applyStimulus(1'b1, 1'b0, 32'h0000_2047, '0);
    tick();
    checkOutput("both_idle_read", 256'(mem_read), 256'(0));
    tick();
    checkOutput("both_read",      256'(mem_read),    256'(1));
    checkOutput("both_read_addr", 256'(mem_address), 256'(32'h0000_2040));
    tick();
    serveRead(fill_c);
    checkOutput("both_rd_resp",  256'(line_resp), 256'(1));
    checkOutput("both_rd_rdata", line_rdata,      fill_c);
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    tick();
    checkOutput("both_xfers", 256'(num_xfers), 256'(2));

    // Stray handshakes while idle
    doReset();
    for (int i = 0; i < 3; i++) begin
      mem_resp = 1'b1;
      tick();
      checkOutput("stray_resp",  256'(line_resp), 256'(0));
      checkOutput("stray_read",  256'(mem_read | mem_write), 256'(0));
      checkOutput("stray_busy",  256'(num_busy),  256'(0));
      checkOutput("stray_xfers", 256'(num_xfers), 256'(0));
    end
    mem_resp = 1'b0;

    // Reset after two read beats, then a clean fill
    applyStimulus(1'b1, 1'b0, 32'h4000_0000, '0);
    tick();
    tick();
    for (int b = 0; b < 2; b++) begin
      mem_resp  = 1'b1;
      mem_rdata = fill_e[b*64 +: 64];
      tick();
    end
    checkOutput("part_rdata", line_rdata, {128'h0, fill_e[127:0]});
    mem_resp = 1'b0;
    rst      = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    tick();
    checkOutput("mid_rst_read",  256'(mem_read),  256'(0));
    checkOutput("mid_rst_resp",  256'(line_resp), 256'(0));
    checkOutput("mid_rst_rdata", line_rdata,      256'(0));
    checkOutput("mid_rst_busy",  256'(num_busy),  256'(0));
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h4000_0040, '0);
    tick();
    checkOutput("clean_read", 256'(mem_read),    256'(1));
    checkOutput("clean_addr", 256'(mem_address), 256'(32'h4000_0040));
    tick();
    serveRead(fill_d);
    checkOutput("clean_resp",  256'(line_resp), 256'(1));
    checkOutput("clean_rdata", line_rdata,      fill_d);
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    tick();
    checkOutput("clean_xfers", 256'(num_xfers), 256'(1));

    // Back-to-back fills with the request still high during line_resp
    applyStimulus(1'b1, 1'b0, 32'h7000_0000, '0);
    tick();
    tick();
    serveRead(fill_e);
    checkOutput("b2b_resp1",  256'(line_resp), 256'(1));
    checkOutput("b2b_rdata1", line_rdata,      fill_e);
    applyStimulus(1'b1, 1'b0, 32'h7000_0020, '0);
    tick();
    checkOutput("b2b_gap_read", 256'(mem_read),  256'(0));
    checkOutput("b2b_gap_resp", 256'(line_resp), 256'(0));
    tick();
    checkOutput("b2b_read2", 256'(mem_read),    256'(1));
    checkOutput("b2b_addr2", 256'(mem_address), 256'(32'h7000_0020));
    tick();
    serveRead(fill_f);
    checkOutput("b2b_resp2",  256'(line_resp), 256'(1));
    checkOutput("b2b_rdata2", line_rdata,      fill_f);
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    tick();
    checkOutput("b2b_xfers", 256'(num_xfers), 256'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
